// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads synchronous instruction memory, hands
// each word to the cpu with run, and advances on done. Counts retirements and flags hangs.
module fetch_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned INST_W  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] d_inst,
   output logic              run,
   input  logic              done,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic [15:0]       retired,
   output logic              err_timeout
);

   localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {StIdle, StAddr, StData, StExec, StNext} state_e;

   state_e            state_q;
   logic [WDOG_W-1:0] wdog_q;

   assign imem_addr = pc;
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         pc          <= '0;
         d_inst      <= '0;
         run         <= 1'b0;
         retired     <= '0;
         err_timeout <= 1'b0;
         wdog_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !err_timeout) state_q <= StAddr;
            end
            StAddr: begin
               state_q <= StData;
            end
            StData: begin
               d_inst  <= imem_rdata;
               run     <= 1'b1;
               wdog_q  <= '0;
               state_q <= StExec;
            end
            StExec: begin
               if (done) begin
                  // run drops on the same edge done is seen so the word is never re-executed
                  run     <= 1'b0;
                  pc      <= br_taken ? br_target : pc + ADDR_W'(1);
                  if (retired != 16'hFFFF) retired <= retired + 16'd1;
                  state_q <= StNext;
               end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  run         <= 1'b0;
                  state_q     <= StIdle;
               end else begin
                  wdog_q <= wdog_q + WDOG_W'(1);
               end
            end
            StNext: begin
               state_q <= start ? StAddr : StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
